// File: rtl/alu_accumulator_pkg.sv
// rtl/alu_accumulator_pkg.sv - shared encodings for the ALU accumulator
package alu_accumulator_pkg;

    typedef enum logic [1:0] {
        FN_ADD = 2'd0,
        FN_OR  = 2'd1,
        FN_AND = 2'd2,
        FN_CAT = 2'd3
    } fn_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_accumulator_if.sv
// rtl/alu_accumulator_if.sv - command/result handshake bundle for the ALU accumulator
interface alu_accumulator_if #(parameter int N = 4);

    logic [N-1:0]   a;
    logic [1:0]     func;
    logic           cmd_clear;
    logic           cmd_valid;
    logic           cmd_ready;
    logic           res_valid;
    logic           res_ready;
    logic [2*N-1:0] aluout;
    logic [7:0]     op_count;

    modport master (
        output a, func, cmd_clear, cmd_valid, res_ready,
        input  cmd_ready, res_valid, aluout, op_count
    );

    modport slave (
        input  a, func, cmd_clear, cmd_valid, res_ready,
        output cmd_ready, res_valid, aluout, op_count
    );

endinterface

// File: rtl/alu_accumulator_alu_core.sv
// rtl/alu_accumulator_alu_core.sv - combinational four-function ALU
module alu_core
    import alu_accumulator_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  fn_t            func,
    output logic [2*N-1:0] y
);

    always_comb begin
        y = '0;
        unique case (func)
            FN_ADD: y[N:0] = {1'b0, a} + {1'b0, b};
            FN_OR:  y[0]   = |{a, b};
            FN_AND: y[0]   = &{a, b};
            FN_CAT: y      = {a, b};
            default: y     = '0;
        endcase
    end

endmodule

// File: rtl/alu_accumulator.sv
// rtl/alu_accumulator.sv - handshaked accumulator around alu_core
module alu_accumulator
    import alu_accumulator_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_accumulator_if.slave bus
);

    state_t         state_q, state_d;
    logic [N-1:0]   a_q;
    fn_t            fn_q;
    logic           clr_q;
    logic [2*N-1:0] r_q;
    logic [2*N-1:0] alu_y;
    logic [7:0]     cnt_q;
    logic           accept;
    logic           handshake;

    // Operand B is always the low half of the result register as it stood before this op.
    alu_core #(.N(N)) u_alu (
        .a    (a_q),
        .b    (r_q[N-1:0]),
        .func (fn_q),
        .y    (alu_y)
    );

    always_comb begin
        state_d       = state_q;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) state_d = EXEC;
            end
            EXEC: state_d = HOLD;
            HOLD: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept    = (state_q == IDLE) && bus.cmd_valid;
    assign handshake = (state_q == HOLD) && bus.res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            fn_q    <= FN_ADD;
            clr_q   <= 1'b0;
            r_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= bus.a;
                fn_q  <= fn_t'(bus.func);
                clr_q <= bus.cmd_clear;
            end
            if (state_q == EXEC) r_q <= clr_q ? '0 : alu_y;
            if (handshake) cnt_q <= cnt_q + 8'd1;
        end
    end

    assign bus.aluout   = r_q;
    assign bus.op_count = cnt_q;

endmodule

// File: tb/tb_alu_accumulator.sv
// tb/tb_alu_accumulator.sv - randomized self-checking bench for alu_accumulator
module tb_alu_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_accumulator_if #(.N(4)) bus();

    alu_accumulator #(.N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: result register, handshake count, and where the current command stands.
    logic [7:0] m_r;
    logic [7:0] m_cnt;
    logic [7:0] m_pend;
    int         m_phase;

    function automatic logic [7:0] model_fn(int a, int f, int b, bit clr);
        if (clr) return 8'd0;
        case (f)
            0:       return 8'(a + b);
            1:       return (a != 0 || b != 0) ? 8'd1 : 8'd0;
            2:       return (a == 15 && b == 15) ? 8'd1 : 8'd0;
            default: return 8'(a * 16 + b);
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_r     <= 8'd0;
            m_cnt   <= 8'd0;
            m_pend  <= 8'd0;
            m_phase <= 0;
        end else begin
            case (m_phase)
                0: if (bus.cmd_valid) begin
                    m_pend  <= model_fn(int'(bus.a), int'(bus.func), int'(m_r) % 16, bus.cmd_clear);
                    m_phase <= 1;
                end
                1: begin
                    m_r     <= m_pend;
                    m_phase <= 2;
                end
                default: if (bus.res_ready) begin
                    m_cnt   <= m_cnt + 8'd1;
                    m_phase <= 0;
                end
            endcase
        end
    end

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_aluout",    int'(bus.aluout),    int'(m_r));
            check("cyc_op_count",  int'(bus.op_count),  int'(m_cnt));
            check("cyc_cmd_ready", int'(bus.cmd_ready), (m_phase == 0) ? 1 : 0);
            check("cyc_res_valid", int'(bus.res_valid), (m_phase == 2) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [3:0] a, input logic [1:0] f, input bit clr,
                           input logic [7:0] exp, input string nm);
        int n;
        bus.a = a; bus.func = f; bus.cmd_clear = clr;
        bus.cmd_valid = 1'b1; bus.res_ready = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin tick(); n++; end
        if (n >= 20) check({nm, "_ready_timeout"}, 0, 1);
        tick();
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.res_valid && n < 20) begin tick(); n++; end
        check({nm, "_latency"}, n, 1);
        check({nm, "_aluout"}, int'(bus.aluout), int'(exp));
        tick();
    endtask

    task automatic rand_cmd();
        int n;
        bit rr;
        bus.a = 4'($urandom); bus.func = 2'($urandom);
        bus.cmd_clear = ($urandom_range(0, 7) == 0);
        bus.cmd_valid = 1'b1; bus.res_ready = 1'($urandom);
        n = 0;
        while (!bus.cmd_ready && n < 20) begin tick(); n++; end
        if (n >= 20) check("rand_ready_timeout", 0, 1);
        tick();
        bus.cmd_valid = 1'($urandom); bus.a = 4'($urandom); bus.res_ready = 1'($urandom);
        tick();
        if (!bus.res_valid) check("rand_hold_timeout", 0, 1);
        rr = 1'b0;
        n = 0;
        while (!rr && n < 8) begin
            rr = (n == 7) ? 1'b1 : 1'($urandom);
            bus.res_ready = rr;
            bus.cmd_valid = 1'($urandom);
            bus.a = 4'($urandom);
            tick();
            n++;
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.a = '0; bus.func = '0; bus.cmd_clear = 1'b0;
        bus.cmd_valid = 1'b0; bus.res_ready = 1'b0;
        #2 rst = 1'b1;
        #2;
        check("rst_aluout",    int'(bus.aluout),    0);
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_cmd_ready", int'(bus.cmd_ready), 1);
        check("rst_op_count",  int'(bus.op_count),  0);
        tick();
        rst = 1'b0;
        chk_en = 1'b1;

        run_cmd(4'h5, 2'd0, 1'b0, 8'h05, "add5");
        run_cmd(4'h3, 2'd0, 1'b0, 8'h08, "add3");
        check("count_two", int'(bus.op_count), 2);
        run_cmd(4'hA, 2'd3, 1'b0, 8'hA8, "cat");
        run_cmd(4'hF, 2'd2, 1'b0, 8'h00, "and");
        run_cmd(4'h1, 2'd1, 1'b0, 8'h01, "or");
        run_cmd(4'hE, 2'd0, 1'b0, 8'h0F, "to0f");
        run_cmd(4'hF, 2'd0, 1'b0, 8'h1E, "carry");

        // Result held under backpressure while junk commands are offered.
        bus.a = 4'hA; bus.func = 2'd3; bus.cmd_clear = 1'b0;
        bus.cmd_valid = 1'b1; bus.res_ready = 1'b0;
        tick();
        tick();
        check("bp_valid", int'(bus.res_valid), 1);
        for (int i = 0; i < 10; i++) begin
            bus.a = 4'(i * 5 + 1);
            bus.cmd_valid = 1'b1;
            tick();
            check("bp_aluout",    int'(bus.aluout),    8'hAE);
            check("bp_cmd_ready", int'(bus.cmd_ready), 0);
            check("bp_op_count",  int'(bus.op_count),  7);
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        check("bp_release_count", int'(bus.op_count),  8);
        check("bp_release_ready", int'(bus.cmd_ready), 1);
        bus.res_ready = 1'b0;
        tick();
        tick();
        check("bp_single_hs", int'(bus.op_count), 8);

        run_cmd(4'h0, 2'd2, 1'b0, 8'h00, "and0");
        run_cmd(4'h8, 2'd0, 1'b0, 8'h08, "add8");
        run_cmd(4'hA, 2'd3, 1'b0, 8'hA8, "cat2");
        run_cmd(4'h7, 2'd0, 1'b1, 8'h00, "clear");
        run_cmd(4'h2, 2'd0, 1'b0, 8'h02, "after_clear");
        check("count_13", int'(bus.op_count), 13);

        // Asynchronous reset mid-EXEC.
        bus.a = 4'h3; bus.func = 2'd0; bus.cmd_valid = 1'b1; bus.res_ready = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rexec_aluout",    int'(bus.aluout),    0);
        check("rexec_res_valid", int'(bus.res_valid), 0);
        check("rexec_cmd_ready", int'(bus.cmd_ready), 1);
        check("rexec_op_count",  int'(bus.op_count),  0);
        tick();
        rst = 1'b0;

        // Asynchronous reset mid-HOLD.
        bus.a = 4'h5; bus.func = 2'd0; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        check("rhold_pre_valid",  int'(bus.res_valid), 1);
        check("rhold_pre_aluout", int'(bus.aluout),    8'h05);
        #2 rst = 1'b1;
        #1;
        check("rhold_aluout",    int'(bus.aluout),    0);
        check("rhold_res_valid", int'(bus.res_valid), 0);
        check("rhold_cmd_ready", int'(bus.cmd_ready), 1);
        check("rhold_op_count",  int'(bus.op_count),  0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_count", int'(bus.op_count), 0);

        for (int i = 0; i < 255; i++) rand_cmd();
        tick();
        check("count_255", int'(bus.op_count), 255);
        rand_cmd();
        tick();
        check("count_wrap", int'(bus.op_count), 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
